// File: rtl/mm_ss_countdown_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mm_ss_countdown_timer
//
// Loadable BCD minutes:seconds countdown timer for the microwave cook cycle.
// A time is preset from the keypad path. The time counts down once per
// one-second tick under start/pause control. Expiry is flagged with a
// one-cycle done pulse.
//
// Build option: define DONE_ALARM_EN to add an expiry alarm. The alarm stays
// high for ALARM_SECS ticks after done. Without the macro, alarm is tied low
// and no alarm counter exists.
//
// Parameters
//   MIN_DIGITS  1 or 2 minutes digits (1: min_tens is always 0)
//   TICK_DIV    CLK cycles per one-second tick, 1..2^24
//   ALARM_SECS  alarm length in ticks (DONE_ALARM_EN only)
//
// Ports
//   CLK, Reset_n        clock (rising edge), synchronous active-low reset
//   clear               abort, zero the time, go to IDLE (highest priority)
//   load, ld_*          capture clamped preset digits (ignored while running)
//   start, pause        begin/resume and suspend the countdown
//   minutes_*/seconds_* current time, direct register outputs
//   running             registered, high while in RUN
//   done                one-cycle pulse after the final decrement
//   alarm               expiry alarm (0 unless DONE_ALARM_EN)
// ---------------------------------------------------------------------------
module mm_ss_countdown_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1,
  parameter int ALARM_SECS = 3
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_min_tens,
  input  logic [3:0] ld_min_units,
  input  logic [2:0] ld_sec_tens,
  input  logic [3:0] ld_sec_units,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_units,
  output logic [2:0] seconds_tens,
  output logic [3:0] seconds_units,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

  // 24 bits hold TICK_DIV-1 for the largest legal divider (2^24).
  localparam logic [23:0] PRE_LAST = 24'(TICK_DIV - 1);

  state_t      state_reg, state_next;
  logic [3:0]  mt_reg, mt_next, mu_reg, mu_next, su_reg, su_next;
  logic [2:0]  st_reg, st_next;
  logic [23:0] pre_reg, pre_next;
  logic        running_reg, running_next;
  logic        done_reg, done_next;

  logic [3:0]  dec_mt, dec_mu, dec_su;
  logic [2:0]  dec_st;
  logic [3:0]  ld_mt, ld_mu, ld_su;
  logic [2:0]  ld_st;
  logic        time_zero, last_sec, pre_wrap;

`ifdef DONE_ALARM_EN
  localparam int AW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);
  logic [AW-1:0] alarm_cnt_reg, alarm_cnt_next;
`endif

  // Keypad digits are clamped to legal BCD ranges before capture.
  always_comb begin
    ld_mu = (ld_min_units > 4'd9) ? 4'd9 : ld_min_units;
    ld_su = (ld_sec_units > 4'd9) ? 4'd9 : ld_sec_units;
    ld_st = (ld_sec_tens  > 3'd5) ? 3'd5 : ld_sec_tens;
    if (MIN_DIGITS == 1) begin
      ld_mt = 4'd0;
    end else begin
      ld_mt = (ld_min_tens > 4'd9) ? 4'd9 : ld_min_tens;
    end
  end

  // BCD borrow chain. It is only applied when the time is nonzero, so
  // min_tens never underflows.
  always_comb begin
    dec_mt = mt_reg;
    dec_mu = mu_reg;
    dec_st = st_reg;
    dec_su = su_reg - 4'd1;
    if (su_reg == 4'd0) begin
      dec_su = 4'd9;
      if (st_reg == 3'd0) begin
        dec_st = 3'd5;
        if (mu_reg == 4'd0) begin
          dec_mu = 4'd9;
          dec_mt = mt_reg - 4'd1;
        end else begin
          dec_mu = mu_reg - 4'd1;
        end
      end else begin
        dec_st = st_reg - 3'd1;
      end
    end
  end

  assign time_zero = (mt_reg == 4'd0) && (mu_reg == 4'd0) && (st_reg == 3'd0) && (su_reg == 4'd0);
  assign last_sec  = (mt_reg == 4'd0) && (mu_reg == 4'd0) && (st_reg == 3'd0) && (su_reg == 4'd1);
  assign pre_wrap  = (pre_reg == PRE_LAST);

  always_comb begin
    state_next = state_reg;
    mt_next    = mt_reg;
    mu_next    = mu_reg;
    st_next    = st_reg;
    su_next    = su_reg;
    pre_next   = pre_reg;
    done_next  = 1'b0;
`ifdef DONE_ALARM_EN
    alarm_cnt_next = alarm_cnt_reg;
`endif
    if (clear) begin
      state_next = IDLE;
      mt_next    = 4'd0;
      mu_next    = 4'd0;
      st_next    = 3'd0;
      su_next    = 4'd0;
      pre_next   = '0;
`ifdef DONE_ALARM_EN
      alarm_cnt_next = '0;
`endif
    end else if (load && (state_reg != RUN)) begin
      state_next = IDLE;
      mt_next    = ld_mt;
      mu_next    = ld_mu;
      st_next    = ld_st;
      su_next    = ld_su;
      pre_next   = '0;
`ifdef DONE_ALARM_EN
      alarm_cnt_next = '0;
`endif
    end else begin
      // A load during RUN is dropped and falls through to normal RUN handling.
      case (state_reg)
        IDLE: begin
          if (start && !time_zero) begin
            state_next = RUN;
            pre_next   = '0;
          end
        end
        PAUSED: begin
          // The prescaler is kept so a resumed second is not restarted.
          if (start && !time_zero) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else begin
            pre_next = pre_wrap ? '0 : pre_reg + 24'd1;
            if (pre_wrap) begin
              mt_next = dec_mt;
              mu_next = dec_mu;
              st_next = dec_st;
              su_next = dec_su;
              if (last_sec) begin
                state_next = DONE;
                done_next  = 1'b1;
`ifdef DONE_ALARM_EN
                alarm_cnt_next = AW'(ALARM_SECS);
`endif
              end
            end
          end
        end
        DONE: begin
`ifdef DONE_ALARM_EN
          // The prescaler keeps running here to time the alarm in seconds.
          pre_next = pre_wrap ? '0 : pre_reg + 24'd1;
          if (pre_wrap && (alarm_cnt_reg != '0)) begin
            alarm_cnt_next = alarm_cnt_reg - AW'(1);
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end
    running_next = (state_next == RUN);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      mt_reg      <= 4'd0;
      mu_reg      <= 4'd0;
      st_reg      <= 3'd0;
      su_reg      <= 4'd0;
      pre_reg     <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
`ifdef DONE_ALARM_EN
      alarm_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      mt_reg      <= mt_next;
      mu_reg      <= mu_next;
      st_reg      <= st_next;
      su_reg      <= su_next;
      pre_reg     <= pre_next;
      running_reg <= running_next;
      done_reg    <= done_next;
`ifdef DONE_ALARM_EN
      alarm_cnt_reg <= alarm_cnt_next;
`endif
    end
  end

  assign minutes_tens  = mt_reg;
  assign minutes_units = mu_reg;
  assign seconds_tens  = st_reg;
  assign seconds_units = su_reg;
  assign running       = running_reg;
  assign done          = done_reg;
`ifdef DONE_ALARM_EN
  assign alarm = (alarm_cnt_reg != '0);
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_mm_ss_countdown_timer.sv
`timescale 1ns/1ps
// Bench for mm_ss_countdown_timer. There are three instances on shared inputs:
//   dut  : MIN_DIGITS=2, TICK_DIV=1 (main vector table)
//   dut4 : TICK_DIV=4 (pause/resume prescaler sequence)
//   dut1 : MIN_DIGITS=1 (minutes-tens forcing)
module tb_mm_ss_countdown_timer;

`ifdef DONE_ALARM_EN
  localparam int ALARM_BUILD = 1;
`else
  localparam int ALARM_BUILD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, clear, load, start, pause;
  logic [3:0] ld_min_tens, ld_min_units, ld_sec_units;
  logic [2:0] ld_sec_tens;

  logic [3:0] mt0, mu0, su0, mt4, mu4, su4, mt1, mu1, su1;
  logic [2:0] st0, st4, st1;
  logic run0, done0, alarm0, run4, done4, alarm4, run1, done1, alarm1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mm_ss_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(1), .ALARM_SECS(3)) dut (
    .CLK(clk), .Reset_n(rst_n), .clear(clear), .load(load),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .start(start), .pause(pause),
    .minutes_tens(mt0), .minutes_units(mu0), .seconds_tens(st0), .seconds_units(su0),
    .running(run0), .done(done0), .alarm(alarm0));

  mm_ss_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(4), .ALARM_SECS(3)) dut4 (
    .CLK(clk), .Reset_n(rst_n), .clear(clear), .load(load),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .start(start), .pause(pause),
    .minutes_tens(mt4), .minutes_units(mu4), .seconds_tens(st4), .seconds_units(su4),
    .running(run4), .done(done4), .alarm(alarm4));

  mm_ss_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(1), .ALARM_SECS(3)) dut1 (
    .CLK(clk), .Reset_n(rst_n), .clear(clear), .load(load),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .start(start), .pause(pause),
    .minutes_tens(mt1), .minutes_units(mu1), .seconds_tens(st1), .seconds_units(su1),
    .running(run1), .done(done1), .alarm(alarm1));

  typedef struct {
    string name;
    int rn, cl, ld, sa, pa;
    int lmt, lmu, lst, lsu;
    int emt, emu, est, esu, er, ed, ea;
  } vec_t;

  vec_t vq[$];

  task automatic add(input vec_t v);
    vq.push_back(v);
  endtask

  function automatic logic [17:0] pk(input int mt, input int mu, input int st, input int su,
                                     input int r, input int d, input int a);
    return {4'(mt), 4'(mu), 3'(st), 4'(su), 1'(r), 1'(d), 1'(a)};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d%0d:%0d%0d run=%b done=%b alarm=%b, required %0d%0d:%0d%0d run=%b done=%b alarm=%b",
               name, act[17:14], act[13:10], act[9:7], act[6:3], act[2], act[1], act[0],
               exp[17:14], exp[13:10], exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: %0d%0d:%0d%0d run=%b done=%b alarm=%b",
               name, act[17:14], act[13:10], act[9:7], act[6:3], act[2], act[1], act[0]);
    end
  endtask

  task automatic drive(input int rn, input int cl, input int ld, input int sa, input int pa,
                       input int lmt, input int lmu, input int lst, input int lsu);
    rst_n        = 1'(rn);
    clear        = 1'(cl);
    load         = 1'(ld);
    start        = 1'(sa);
    pause        = 1'(pa);
    ld_min_tens  = 4'(lmt);
    ld_min_units = 4'(lmu);
    ld_sec_tens  = 3'(lst);
    ld_sec_units = 4'(lsu);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] act0();
    return {mt0, mu0, st0, su0, run0, done0, alarm0};
  endfunction
  function automatic logic [17:0] act4();
    return {mt4, mu4, st4, su4, run4, done4, alarm4};
  endfunction
  function automatic logic [17:0] act1();
    return {mt1, mu1, st1, su1, run1, done1, alarm1};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, rn,cl,ld,sa,pa, lmt,lmu,lst,lsu, emt,emu,est,esu, run,done,alarm
    add('{"rst_with_ld_start", 0,0,1,1,0, 9,9,5,9, 0,0,0,0, 0,0,0});
    add('{"rst_second_edge",   0,0,1,1,0, 9,9,5,9, 0,0,0,0, 0,0,0});
    add('{"load_00_05",        1,0,1,0,0, 0,0,0,5, 0,0,0,5, 0,0,0});
    add('{"start_00_05",       1,0,0,1,0, 0,0,0,0, 0,0,0,5, 1,0,0});
    add('{"count_00_04",       1,0,0,0,0, 0,0,0,0, 0,0,0,4, 1,0,0});
    add('{"count_00_03",       1,0,0,0,0, 0,0,0,0, 0,0,0,3, 1,0,0});
    add('{"count_00_02",       1,0,0,0,0, 0,0,0,0, 0,0,0,2, 1,0,0});
    add('{"count_00_01",       1,0,0,0,0, 0,0,0,0, 0,0,0,1, 1,0,0});
    add('{"expire",            1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,1});
    add('{"done_hold",         1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1});
    add('{"start_in_done",     1,0,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,1});
    add('{"alarm_end",         1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0});
    add('{"load_10_00",        1,0,1,0,0, 1,0,0,0, 1,0,0,0, 0,0,0});
    add('{"start_10_00",       1,0,0,1,0, 0,0,0,0, 1,0,0,0, 1,0,0});
    add('{"borrow_09_59",      1,0,0,0,0, 0,0,0,0, 0,9,5,9, 1,0,0});
    add('{"pause",             1,0,0,0,1, 0,0,0,0, 0,9,5,9, 0,0,0});
    add('{"load_01_00_paused", 1,0,1,0,0, 0,1,0,0, 0,1,0,0, 0,0,0});
    add('{"start_01_00",       1,0,0,1,0, 0,0,0,0, 0,1,0,0, 1,0,0});
    add('{"borrow_00_59",      1,0,0,0,0, 0,0,0,0, 0,0,5,9, 1,0,0});
    add('{"load_in_run_ign",   1,0,1,0,0, 5,5,5,5, 0,0,5,8, 1,0,0});
    add('{"clear_start_run",   1,1,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0});
    add('{"clamp_sec",         1,0,1,0,0, 0,0,7,12, 0,0,5,9, 0,0,0});
    add('{"clear",             1,1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0});
    add('{"start_at_zero",     1,0,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0});
    add('{"clamp_all",         1,0,1,0,0, 12,15,6,10, 9,9,5,9, 0,0,0});
    add('{"start_99_59",       1,0,0,1,0, 0,0,0,0, 9,9,5,9, 1,0,0});
    add('{"count_99_58",       1,0,0,0,0, 0,0,0,0, 9,9,5,8, 1,0,0});
    add('{"pause_99_58",       1,0,0,0,1, 0,0,0,0, 9,9,5,8, 0,0,0});
    add('{"pause_in_paused",   1,0,0,0,1, 0,0,0,0, 9,9,5,8, 0,0,0});
    add('{"resume",            1,0,0,1,0, 0,0,0,0, 9,9,5,8, 1,0,0});
    add('{"count_99_57",       1,0,0,0,0, 0,0,0,0, 9,9,5,7, 1,0,0});
    add('{"reset_mid_count",   0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0});
    add('{"start_after_reset", 1,0,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0});

    foreach (vq[i]) begin
      drive(vq[i].rn, vq[i].cl, vq[i].ld, vq[i].sa, vq[i].pa,
            vq[i].lmt, vq[i].lmu, vq[i].lst, vq[i].lsu);
      cyc();
      check(vq[i].name, act0(),
            pk(vq[i].emt, vq[i].emu, vq[i].est, vq[i].esu, vq[i].er, vq[i].ed,
               vq[i].ea & ALARM_BUILD));
    end

    // TICK_DIV=4: the first decrement lands on the 4th RUN edge. Pausing
    // freezes the prescaler at 2, so the next tick comes 2 edges after resume.
    drive(0,0,0,0,0, 0,0,0,0); cyc();
    drive(1,0,1,0,0, 0,0,1,0); cyc();
    check("d4_load_00_10", act4(), pk(0,0,1,0, 0,0,0));
    drive(1,0,0,1,0, 0,0,0,0); cyc();
    check("d4_start", act4(), pk(0,0,1,0, 1,0,0));
    drive(1,0,0,0,0, 0,0,0,0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 3) check("d4_before_tick", act4(), pk(0,0,1,0, 1,0,0));
      if (k == 4) check("d4_first_tick", act4(), pk(0,0,0,9, 1,0,0));
    end
    drive(1,0,0,0,1, 0,0,0,0); cyc();
    check("d4_pause", act4(), pk(0,0,0,9, 0,0,0));
    drive(1,0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("d4_frozen_%0d", k), act4(), pk(0,0,0,9, 0,0,0));
    end
    drive(1,0,0,1,0, 0,0,0,0); cyc();
    check("d4_resume", act4(), pk(0,0,0,9, 1,0,0));
    drive(1,0,0,0,0, 0,0,0,0); cyc();
    check("d4_resume_plus1", act4(), pk(0,0,0,9, 1,0,0));
    cyc();
    check("d4_resume_plus2", act4(), pk(0,0,0,8, 1,0,0));

    // MIN_DIGITS=1 forces minutes tens to 0; the two-digit instance keeps it.
    drive(0,0,0,0,0, 0,0,0,0); cyc();
    drive(1,0,1,0,0, 1,5,3,0); cyc();
    check("d1_load_15_30", act1(), pk(0,5,3,0, 0,0,0));
    check("d2_load_15_30", act0(), pk(1,5,3,0, 0,0,0));
    drive(1,0,1,0,0, 3,12,3,0); cyc();
    check("d1_load_clamp", act1(), pk(0,9,3,0, 0,0,0));
    drive(1,0,0,1,0, 0,0,0,0); cyc();
    drive(1,0,0,0,0, 0,0,0,0); cyc();
    check("d1_count", act1(), pk(0,9,2,9, 1,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
